pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register; successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle (WB/M/EX bits) and a data bundle (NPC, operands, immediate, register indices) with a valid/ready handshake, stall back-pressure, flush-to-bubble and a one-entry skid buffer.
- Gives full throughput without a combinational ready path from the downstream stage.

Parameters:
- CTRL_W, 9, width of the control bundle; forced to zero whenever the stage holds a bubble.
- DATA_W, 138, width of the data bundle; held, never zeroed except at reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  discard all held and incoming entries this cycle
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept; registered, equals skid-empty
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  entry present toward downstream
- out_ready  input  1  downstream accepts this cycle
- out_ctrl  output  CTRL_W  control bundle; 0 when out_valid=0
- out_data  output  DATA_W  data bundle

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising clk edge.
- Reset (rst_n=0 at an edge):
  - main_valid=0, skid_valid=0.
  - out_ctrl=0, out_data=0, skid contents=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) plus one skid entry. in_ready = !skid_valid, taken directly from a flop.
- Priority at each edge, highest first:
  1. Reset.
  2. Flush: main_valid=0, skid_valid=0, out_ctrl=0; an in_fire in the same cycle is dropped; out_data holds its value.
  3. Normal operation (rules below).
- Normal operation, case main empty or out_ready=1:
  - If skid_valid: main loads the skid entry and skid_valid=0.
  - Else if in_fire: main loads the input and main_valid=1.
  - Else: main_valid=0, out_ctrl=0, out_data holds.
- Normal operation, case main_valid=1 and out_ready=0 (stall):
  - main holds.
  - If in_fire: skid loads the input and skid_valid=1, so in_ready drops the next cycle.
- Latency: 1 cycle from in_fire to out_valid when empty.
- Throughput: 1 entry per cycle while out_ready=1.
- Ordering: strict FIFO, at most 2 entries held. No entry is lost or duplicated except by flush.
- Bubble rule: out_ctrl == 0 whenever out_valid == 0, so a bubble can never assert RegWrite/MemWrite/Branch downstream.
- Simultaneous skid drain and in_fire cannot occur, because in_ready=0 while the skid is full.
- Reset asserted mid-stall: all entries are discarded with no partial update.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0], both reset to 0 under rst_n.
  - stall_cnt increments on every cycle with out_valid & !out_ready.
  - bubble_cnt increments on every cycle with !out_valid, and on every flush cycle that discards at least one valid entry.
  - Both counters wrap modulo 2^32.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then streaming: rst_n low 2 cycles, then in_valid=1 every cycle with in_data=1,2,3,4 and out_ready=1. Required: out_data 1,2,3,4 on consecutive cycles, each one cycle after its in_fire; in_ready stays 1.
- Stall with skid: load A=0x10, then B=0x20 while out_ready=0. Required: skid_valid=1, in_ready=0 next cycle, out_data=0x10 held. Raise out_ready: 0x10, then 0x20 on consecutive cycles, in_ready returns to 1.
- Flush with both entries full plus in_valid=1 (C=0x30), in_ctrl=0x1FF. Required: next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x30 never appears at the output.
- Bubble control zeroing: single entry with in_ctrl=0x1FF, out_ready=1, no further input. Required: out_ctrl=0x1FF for one cycle, then out_ctrl=0 with out_valid=0.
- Reset mid-stall: two entries held, rst_n=0 for one cycle. Required: out_valid=0, out_ctrl=0, out_data=0, in_ready=0 during reset, in_ready=1 after release.
- PIPE_STAGE_REG_PERF_EN: 3 stall cycles, then 2 idle cycles, then a flush of 1 valid entry. Required: stall_cnt=3, bubble_cnt=3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: a main entry that drives the outputs plus a
// one-entry skid buffer. in_ready comes straight from a flop, so the
// downstream ready signal has no combinational path back to the upstream stage.
// Bubbles always present an all-zero control bundle.
// Optional build macro: PIPE_STAGE_REG_PERF_EN adds stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 138
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              in_fire;
  logic              main_valid_d;
  logic              skid_valid_d;
  logic              in_ready_d;
  logic [CTRL_W-1:0] out_ctrl_d;
  logic [DATA_W-1:0] out_data_d;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_d;

  // Next-state for the main entry and skid; flush beats normal operation.
  always_comb begin
    in_fire      = in_valid & in_ready;
    main_valid_d = out_valid;
    skid_valid_d = skid_valid;
    out_ctrl_d   = out_ctrl;
    out_data_d   = out_data;
    skid_ctrl_d  = skid_ctrl;
    skid_data_d  = skid_data;

    if (flush) begin
      // Discard everything; data payload is left as-is, only control is zeroed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      out_ctrl_d   = '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        // Skid full implies in_ready=0, so no input can arrive concurrently.
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        out_ctrl_d   = skid_ctrl;
        out_data_d   = skid_data;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        out_ctrl_d   = in_ctrl;
        out_data_d   = in_data;
      end else begin
        main_valid_d = 1'b0;
        out_ctrl_d   = '0;
      end
    end else if (in_fire) begin
      // Main is stalled: park the new entry in the skid.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end

    in_ready_d = !skid_valid_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      out_valid  <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= in_ready_d;
      out_ctrl   <= out_ctrl_d;
      out_data   <= out_data_d;
      skid_ctrl  <= skid_ctrl_d;
      skid_data  <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_REG_PERF_EN
  logic             stall_inc;
  logic             bubble_inc;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_d;

  // Counter increments: stalled output, idle output, or a flush that kills work.
  always_comb begin
    stall_inc    = out_valid & !out_ready;
    bubble_inc   = !out_valid | (flush & (out_valid | skid_valid));
    stall_cnt_d  = stall_cnt;
    bubble_cnt_d = bubble_cnt;
    if (stall_inc)  stall_cnt_d  = stall_cnt + CNT_W'(1);
    if (bubble_inc) bubble_cnt_d = bubble_cnt + CNT_W'(1);
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= stall_cnt_d;
      bubble_cnt <= bubble_cnt_d;
    end
  end
`endif

endmodule
